up_counter_mod: RTL

Parameterized, loadable up counter with a programmable terminal value, selectable wrap or saturate behaviour, and an optional enable prescaler. It is the count-up counterpart of the team's 4-bit free-running down counter. It is used for event and interval counting, where software sets the terminal value and status flags report overflow.

---
 rtl/up_counter_pkg.sv | 12 +
 rtl/up_counter_prescaler.sv | 30 +++
 rtl/up_counter_mod.sv | 80 ++++++++
 3 files changed

// File: rtl/up_counter_pkg.sv
// Shared types and defaults for the loadable up counter.
package up_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_PRESCALE = 1;

endpackage

// File: rtl/up_counter_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled clocks.
module up_counter_prescaler
  import up_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pc;

  assign tick = en && (pc == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (sync_clr) begin
      pc <= '0;
    end else if (en) begin
      pc <= tick ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: rtl/up_counter_mod.sv
// Loadable up counter with programmable terminal value, wrap/saturate mode,
// optional enable prescaler and sticky overflow flag.
module up_counter_mod
  import up_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic tick;
  logic step;
  logic at_limit;
  logic sync_clr;

  assign sync_clr = clr | load;

  generate
    if (PRESCALE > 1) begin : g_pre
      up_counter_prescaler #(
        .PRESCALE (PRESCALE)
      ) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .tick     (tick)
      );
    end else begin : g_nopre
      assign tick = en;
    end
  endgenerate

  // ">=" rather than "==" so a limit lowered under the count still terminates
  assign at_limit = (count >= limit);
  assign step     = tick && !sync_clr;
  assign tc       = step && at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (step) begin
        if (!at_limit) begin
          count <= count + 1'b1;
        end else if (sat_mode == MODE_WRAP) begin
          count <= '0;
          wrap  <= 1'b1;
        end
      end

      if (tc) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
